// File: rtl/shift_reg_ctrl_pkg.sv
// Shared types for the shift-register command sequencer: opcodes, datapath modes, FSM states.
// Latency: n/a (types and helper only).
// Backpressure: n/a.
package shift_reg_ctrl_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD = 3'd0,
        OP_SHL  = 3'd1,
        OP_SHR  = 3'd2,
        OP_ROL  = 3'd3,
        OP_ROR  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        SR_HOLD = 2'd0,
        SR_LOAD = 2'd1,
        SR_SHL  = 2'd2,
        SR_SHR  = 2'd3
    } sr_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Opcodes 5..7 are reserved and answered with an error response.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/shift_reg_ctrl.sv
// Command sequencer: runs LOAD/SHL/SHR/ROL/ROR on an external shift-register datapath, one step per cycle.
// Latency: response T+2 for LOAD, T+n+1 for shift/rotate by n>0, T+1 for amt=0 or illegal op.
// Backpressure: one command in flight; cmd_ready stays low until the response handshake completes.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   cmd_valid/cmd_ready              command handshake; cmd_op, cmd_amt, cmd_fill, cmd_data payload
//   rsp_valid/rsp_ready              response handshake; rsp_data (datapath value), rsp_err (illegal op)
//   sr_mode, sr_din, sr_sin          datapath controls
//   sr_dout                          registered datapath output
module shift_reg_ctrl
    import shift_reg_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_din,
    output logic             sr_sin,
    input  logic [WIDTH-1:0] sr_dout
);

    state_e           state;
    logic [OP_W-1:0]  op_q;
    logic [AMT_W-1:0] cnt;
    sr_mode_e         mode_q;
    logic [WIDTH-1:0] din_q;
    logic             sin_q;
    logic             rsp_valid_q;
    logic             err_q;
    logic             cmd_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            cnt         <= '0;
            mode_q      <= SR_HOLD;
            din_q       <= '0;
            sin_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= cmd_op;
                        if (!op_legal(cmd_op)) begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            err_q       <= 1'b1;
                        end else if (cmd_op == OP_LOAD) begin
                            state  <= ST_EXEC;
                            cnt    <= AMT_W'(1);
                            mode_q <= SR_LOAD;
                            din_q  <= cmd_data;
                        end else if (cmd_amt == '0) begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state  <= ST_EXEC;
                            cnt    <= cmd_amt;
                            mode_q <= (cmd_op == OP_SHL || cmd_op == OP_ROL) ? SR_SHL : SR_SHR;
                            // Rotates take their serial bit from sr_dout instead.
                            sin_q  <= (cmd_op == OP_SHL || cmd_op == OP_SHR) ? cmd_fill : 1'b0;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt == AMT_W'(1)) begin
                        state       <= ST_RESP;
                        mode_q      <= SR_HOLD;
                        din_q       <= '0;
                        sin_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Rotate feedback must see the bit the datapath holds this cycle, so it
    // bypasses the register. Gated by state so reset drops it immediately.
    always_comb begin
        sr_sin = sin_q;
        if (state == ST_EXEC) begin
            if (op_q == OP_ROL)
                sr_sin = sr_dout[WIDTH-1];
            else if (op_q == OP_ROR)
                sr_sin = sr_dout[0];
        end
    end

    // The datapath is frozen in RESP, so its registered output is the result;
    // gating with the registered valid keeps rsp_data at 0 when idle.
    assign rsp_data  = rsp_valid_q ? sr_dout : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = err_q;
    assign cmd_ready = cmd_ready_q;
    assign sr_mode   = mode_q;
    assign sr_din    = din_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl driving a behavioural shift-register datapath.
// Latency: n/a.
// Backpressure: exercises rsp_ready stalls of 0..3 cycles.

// Behavioural 4-bit datapath: HOLD, LOAD, SHL (sin into LSB), SHR (sin into MSB).
module shift_reg_dp #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode,
    input  logic [W-1:0] din,
    input  logic         sin,
    output logic [W-1:0] dout
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dout <= '0;
        else begin
            case (mode)
                2'd1:    dout <= din;
                2'd2:    dout <= {dout[W-2:0], sin};
                2'd3:    dout <= {sin, dout[W-1:1]};
                default: dout <= dout;
            endcase
        end
    end
endmodule

module tb_shift_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dp_rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [2:0] cmd_amt = '0;
    logic       cmd_fill = 1'b0;
    logic [3:0] cmd_data = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       rsp_err;
    logic [1:0] sr_mode;
    logic [3:0] sr_din;
    logic       sr_sin;
    logic [3:0] sr_dout;

    int errs = 0;
    int checks = 0;
    logic [3:0] model = 4'h0;

    always #5 clk = ~clk;

    shift_reg_ctrl #(.WIDTH(4), .AMT_W(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_fill(cmd_fill), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .sr_mode(sr_mode), .sr_din(sr_din), .sr_sin(sr_sin), .sr_dout(sr_dout)
    );

    shift_reg_dp #(.W(4)) u_dp (
        .clk(clk), .rst(dp_rst), .mode(sr_mode), .din(sr_din), .sin(sr_sin), .dout(sr_dout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Result of a whole command computed in closed form from the command semantics.
    function automatic logic [3:0] ref_result(input int op, input int amt, input bit fill,
                                              input logic [3:0] data, input logic [3:0] cur);
        int v, k, ones;
        v = int'(cur);
        case (op)
            0: return data;
            1: begin
                if (amt >= 4) return fill ? 4'hF : 4'h0;
                ones = fill ? ((1 << amt) - 1) : 0;
                return 4'(((v << amt) | ones) & 15);
            end
            2: begin
                if (amt >= 4) return fill ? 4'hF : 4'h0;
                ones = fill ? (((1 << amt) - 1) << (4 - amt)) : 0;
                return 4'(((v >> amt) | ones) & 15);
            end
            3: begin
                k = amt % 4;
                return 4'(((v << k) | (v >> (4 - k))) & 15);
            end
            4: begin
                k = amt % 4;
                return 4'(((v >> k) | (v << (4 - k))) & 15);
            end
            default: return cur;
        endcase
    endfunction

    task automatic run_cmd(input int op, input int amt, input bit fill, input logic [3:0] data,
                           input int hold);
        logic [3:0] exp_v;
        logic [3:0] held;
        int exp_lat, exp_steps, exp_mode, lat, steps, bad;
        bit seen;
        logic [2:0] op3, amt3;

        exp_v     = ref_result(op, amt, fill, data, model);
        exp_lat   = (op > 4) ? 1 : (op == 0) ? 2 : (amt == 0) ? 1 : amt + 1;
        exp_steps = (op > 4) ? 0 : (op == 0) ? 1 : amt;
        exp_mode  = (op == 0) ? 1 : (op == 1 || op == 3) ? 2 : 3;
        op3  = 3'(op);
        amt3 = 3'(amt);

        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op3;
        cmd_amt   = amt3;
        cmd_fill  = fill;
        cmd_data  = data;
        @(posedge clk);
        #1 cmd_valid = 1'b0;

        lat = 0; steps = 0; bad = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (sr_mode != 2'd0) begin
                steps++;
                if (int'(sr_mode) != exp_mode) bad++;
                if (sr_mode == 2'd1 && sr_din != data) bad++;
            end
            if (rsp_valid) seen = 1'b1;
            else chk("cmd_ready_busy", 32'(cmd_ready), 0);
        end
        chk("rsp_seen", 32'(seen), 1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("steps", 32'(steps), 32'(exp_steps));
        chk("mode_din", 32'(bad), 0);
        chk("rsp_data", 32'(rsp_data), 32'(exp_v));
        chk("rsp_err", 32'(rsp_err), (op > 4) ? 1 : 0);

        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", 32'(rsp_data), 32'(held));
            chk("hold_ready", 32'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("ready_after_hs", 32'(cmd_ready), 1);
        chk("valid_after_hs", 32'(rsp_valid), 0);
        model = exp_v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, amt;
        bit fill;

        // Reset state
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_sr_mode", 32'(sr_mode), 0);
        chk("rst_sr_din", 32'(sr_din), 0);
        chk("rst_sr_sin", 32'(sr_sin), 0);
        @(negedge clk);
        rst = 1'b0;
        dp_rst = 1'b0;

        // Directed scenarios
        run_cmd(0, 0, 0, 4'hA, 0);   // LOAD A
        run_cmd(1, 1, 0, 4'h0, 0);   // SHL 1 fill 0 -> 4
        run_cmd(0, 0, 0, 4'hA, 0);
        run_cmd(2, 2, 1, 4'h0, 0);   // SHR 2 fill 1 -> E
        run_cmd(0, 0, 0, 4'h9, 0);
        run_cmd(3, 5, 0, 4'h0, 0);   // ROL 5 -> 3
        run_cmd(0, 0, 0, 4'h9, 0);
        run_cmd(4, 4, 0, 4'h0, 0);   // ROR 4 -> 9
        run_cmd(1, 0, 1, 4'h0, 0);   // SHL 0: no activity
        run_cmd(6, 3, 1, 4'h5, 0);   // illegal op
        run_cmd(2, 7, 1, 4'h0, 3);   // shift past width, stalled response
        run_cmd(1, 4, 0, 4'h0, 3);

        // Reset in the 3rd EXEC cycle of SHR 7
        run_cmd(0, 0, 0, 4'h6, 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_amt = 3'd7; cmd_fill = 1'b1; cmd_data = 4'h0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_sr_mode", 32'(sr_mode), 0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_sr_sin", 32'(sr_sin), 0);
        model = ref_result(2, 2, 1'b1, 4'h0, model);   // two steps completed before reset
        @(negedge clk);
        rst = 1'b0;
        run_cmd(1, 0, 0, 4'h0, 0);   // reads back the partial result
        run_cmd(4, 3, 0, 4'h0, 1);

        // Randomized commands
        for (int i = 0; i < 30; i++) begin
            op   = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
            amt  = int'($urandom_range(0, 7));
            fill = 1'($urandom_range(0, 1));
            run_cmd(op, amt, fill, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
